// File: rtl/aes_pkg.sv
// Shared AES controller definitions: state codes for the encryption and decryption managers
// (kept disjoint so dbg_state is unambiguous) and the state-matrix input mux encodings.
package aes_pkg;

  localparam int unsigned NumRoundsDefault = 10;

  typedef enum logic [5:0] {
    EncIdle            = 6'd0,
    EncPtextWrite      = 6'd1,
    EncKeyWrite        = 6'd2,
    EncComputeRoundkeys = 6'd3,
    EncAddRoundKey     = 6'd4,
    EncSubBytes        = 6'd5,
    EncShiftRows       = 6'd6,
    EncMixColumns      = 6'd7,
    EncEncryptionDone  = 6'd8,
    EncCtextRead       = 6'd9
  } enc_state_e;

  typedef enum logic [5:0] {
    StIdle             = 6'd0,
    StCtextWrite       = 6'd1,
    StKeyWrite         = 6'd2,
    StComputeRoundkeys = 6'd3,
    StInvAddRoundKey   = 6'd10,
    StInvShiftRows     = 6'd11,
    StInvSubBytes      = 6'd12,
    StInvMixColumns    = 6'd13,
    StDecryptionDone   = 6'd14,
    StPtextRead        = 6'd15
  } dec_state_e;

  typedef enum logic [3:0] {
    SelExternal      = 4'd0,
    SelSubBytes      = 4'd1,
    SelShiftRows     = 4'd2,
    SelMixColumns    = 4'd3,
    SelAddRoundKey   = 4'd4,
    SelInvSubBytes   = 4'd5,
    SelInvShiftRows  = 4'd6,
    SelInvMixColumns = 4'd7
  } mat_sel_e;

  // States that walk the matrix one row/column per cycle for exactly four cycles.
  function automatic logic is_step_state(input dec_state_e st);
    return st inside {StCtextWrite, StKeyWrite, StInvAddRoundKey, StInvShiftRows,
                      StInvSubBytes, StInvMixColumns, StPtextRead};
  endfunction

endpackage

// File: rtl/aes_decrypt_manager_if.sv
// Handshake and state-matrix control bus of the AES decryption manager.
interface aes_decrypt_manager_if;
  logic       start_write_n;
  logic       start_read_n;
  logic       key_expand_done;
  logic       done;
  logic       busy;
  logic [5:0] dbg_state;
  logic [3:0] dbg_round;
  logic [3:0] round_key_idx;
  logic [3:0] matrix_in_sel;
  logic       matrix_write_enable;
  logic       key_write_enable;
  logic       mat_row_col;
  logic       mat_read_write;
  logic [1:0] mat_idx;

  modport master (
    input  start_write_n, start_read_n, key_expand_done,
    output done, busy, dbg_state, dbg_round, round_key_idx, matrix_in_sel,
           matrix_write_enable, key_write_enable, mat_row_col, mat_read_write, mat_idx
  );

  modport slave (
    output start_write_n, start_read_n, key_expand_done,
    input  done, busy, dbg_state, dbg_round, round_key_idx, matrix_in_sel,
           matrix_write_enable, key_write_enable, mat_row_col, mat_read_write, mat_idx
  );
endinterface

// File: rtl/aes_step_counter.sv
// Two-bit step counter pacing the four-cycle load, operation and readout states.
module aes_step_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  output logic [1:0] count,
  output logic       terminal
);

  logic [1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == 2'd3);

endmodule

// File: rtl/aes_decrypt_manager.sv
// AES-128 inverse-cipher sequencer driving the shared state-matrix control bus.
// Optional AES_DEC_ABORT_EN adds a synchronous active-low abort_n input.
module aes_decrypt_manager
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NumRoundsDefault
) (
  input logic clock,
  input logic reset_n,
`ifdef AES_DEC_ABORT_EN
  input logic abort_n,
`endif
  aes_decrypt_manager_if.master bus
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  dec_state_e state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       done_q, done_d;
  logic [1:0] count_4;
  logic       step_last;
  logic       busy;

  aes_step_counter u_step_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (state_d != state_q),
    .enable   (is_step_state(state_q)),
    .count    (count_4),
    .terminal (step_last)
  );

  always_comb begin
    busy = is_step_state(state_q) || (state_q == StComputeRoundkeys);
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle:             if (!bus.start_write_n) state_d = StCtextWrite;
      StCtextWrite:       if (step_last) state_d = StKeyWrite;
      StKeyWrite:         if (step_last) state_d = StComputeRoundkeys;
      StComputeRoundkeys: begin
        if (bus.key_expand_done) begin
          state_d = StInvAddRoundKey;
          round_d = LastRound;
        end
      end
      StInvAddRoundKey: begin
        if (step_last) begin
          if (round_q == 4'd0) begin
            state_d = StDecryptionDone;
          end else if (round_q == LastRound) begin
            // The initial AddRoundKey is not followed by InvMixColumns.
            state_d = StInvShiftRows;
            round_d = round_q - 4'd1;
          end else begin
            state_d = StInvMixColumns;
          end
        end
      end
      StInvMixColumns: begin
        if (step_last) begin
          state_d = StInvShiftRows;
          round_d = round_q - 4'd1;
        end
      end
      StInvShiftRows:     if (step_last) state_d = StInvSubBytes;
      StInvSubBytes:      if (step_last) state_d = StInvAddRoundKey;
      StDecryptionDone:   if (!bus.start_read_n) state_d = StPtextRead;
      StPtextRead: begin
        if (step_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default:            state_d = StIdle;
    endcase
`ifdef AES_DEC_ABORT_EN
    if (!abort_n && busy) begin
      state_d = StIdle;
      round_d = '0;
      done_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bus.matrix_in_sel       = SelExternal;
    bus.matrix_write_enable = 1'b0;
    bus.key_write_enable    = 1'b0;
    bus.mat_row_col         = 1'b0;
    bus.mat_read_write      = 1'b0;
    case (state_q)
      StCtextWrite: begin
        bus.matrix_write_enable = 1'b1;
        bus.mat_row_col         = 1'b1;
        bus.mat_read_write      = 1'b1;
      end
      StKeyWrite: begin
        bus.key_write_enable = 1'b1;
        bus.mat_row_col      = 1'b1;
        bus.mat_read_write   = 1'b1;
      end
      StInvAddRoundKey: begin
        bus.matrix_in_sel = SelAddRoundKey;
        bus.mat_row_col   = 1'b1;
      end
      StInvShiftRows:  bus.matrix_in_sel = SelInvShiftRows;
      StInvSubBytes:   bus.matrix_in_sel = SelInvSubBytes;
      StInvMixColumns: begin
        bus.matrix_in_sel = SelInvMixColumns;
        bus.mat_row_col   = 1'b1;
      end
      StPtextRead:     bus.mat_row_col = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy          = busy;
  assign bus.done          = done_q;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_round     = round_q;
  assign bus.round_key_idx = round_q;
  assign bus.mat_idx       = count_4;

endmodule
